// File: rtl/qpu_sleep_ctrl_pkg.sv
// Shared types and defaults for the core-side WFI/sleep sequencer.
package qpu_sleep_ctrl_pkg;

  // Sleep sequencer states.
  typedef enum logic [1:0] {
    SLP_RUN   = 2'b00,
    SLP_DRAIN = 2'b01,
    SLP_SLEEP = 2'b10,
    SLP_WAKE  = 2'b11
  } slp_state_e;

  localparam int unsigned DEF_HOLD_CYC = 4;
  localparam int unsigned DEF_WAKE_CYC = 2;
  localparam int unsigned DEF_CNT_W    = 3;

  // Any wake source: a pending interrupt or a debug halt request.
  function automatic logic isWakeSrc(input logic irq, input logic dbg);
    return irq | dbg;
  endfunction

endpackage

// File: rtl/qpu_sleep_ctrl_act_hold.sv
// Busy-to-active hysteresis: keeps a unit's active flag high for HOLD_CYC
// cycles after its busy drops, so the gated clock does not chatter.
module qpu_sleep_ctrl_act_hold #(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_busy,
  output logic o_active
);

  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Reload on busy, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= HOLD_VAL;
    end else if (i_busy) begin
      r_cnt <= HOLD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - ONE;
    end
  end

  assign o_active = i_busy | (r_cnt != '0);

endmodule

// File: rtl/qpu_sleep_ctrl.sv
// Core-side WFI/sleep sequencer: halts IFU on a committed WFI, waits for the
// EXU/LSU/BIU to drain, sleeps, and wakes on interrupt or debug halt.
module qpu_sleep_ctrl
  import qpu_sleep_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned WAKE_CYC = DEF_WAKE_CYC,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wfi_req,
  output logic wfi_ack,
  output logic ifu_halt_req,
  input  logic ifu_halt_ack,
  input  logic exu_busy,
  input  logic lsu_busy,
  input  logic biu_busy,
  input  logic irq_pend,
  input  logic dbg_halt,
  output logic core_wfi,
  output logic exu_active,
  output logic lsu_active,
  output logic biu_active,
  output logic wake_evt
);

  localparam logic [CNT_W-1:0] WAKE_VAL = CNT_W'(WAKE_CYC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  slp_state_e       r_state;
  slp_state_e       w_nextState;
  logic [CNT_W-1:0] r_wakeCnt;
  logic [CNT_W-1:0] w_wakeCntNext;
  logic             r_wfiAck;
  logic             r_ifuHalt;
  logic             r_coreWfi;
  logic             r_wakeEvt;
  logic             w_wfiAckNext;
  logic             w_ifuHaltNext;
  logic             w_coreWfiNext;
  logic             w_wakeEvtNext;
  logic             w_wake;
  logic             w_drained;

  assign w_wake    = isWakeSrc(irq_pend, dbg_halt);
  assign w_drained = ifu_halt_ack & ~exu_busy & ~lsu_busy & ~biu_busy;

  // Next-state and next-output decode. The wake counter holds the number of
  // WAKE cycles still to run; a value of 0 or 1 means this is the last one,
  // so WAKE_CYC=0 still gives a single WAKE cycle. The request is ignored in
  // the cycle its acknowledge is visible, since EXU is still holding it then.
  always_comb begin
    w_nextState   = r_state;
    w_wakeCntNext = r_wakeCnt;
    w_wfiAckNext  = 1'b0;
    w_wakeEvtNext = 1'b0;
    unique case (r_state)
      SLP_RUN: begin
        if (wfi_req && !r_wfiAck) begin
          if (w_wake) begin
            w_wfiAckNext = 1'b1;
          end else begin
            w_nextState = SLP_DRAIN;
          end
        end
      end
      SLP_DRAIN: begin
        if (w_wake) begin
          w_nextState   = SLP_WAKE;
          w_wakeCntNext = WAKE_VAL;
        end else if (w_drained) begin
          w_nextState = SLP_SLEEP;
        end
      end
      SLP_SLEEP: begin
        if (w_wake) begin
          w_nextState   = SLP_WAKE;
          w_wakeCntNext = WAKE_VAL;
          w_wakeEvtNext = 1'b1;
        end
      end
      SLP_WAKE: begin
        if (r_wakeCnt <= ONE) begin
          w_nextState   = SLP_RUN;
          w_wakeCntNext = '0;
          w_wfiAckNext  = 1'b1;
        end else begin
          w_wakeCntNext = r_wakeCnt - ONE;
        end
      end
      default: begin
        w_nextState = SLP_RUN;
      end
    endcase
    w_ifuHaltNext = (w_nextState != SLP_RUN);
    w_coreWfiNext = (w_nextState == SLP_SLEEP);
  end

  // State, wake counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= SLP_RUN;
      r_wakeCnt <= '0;
      r_wfiAck  <= 1'b0;
      r_ifuHalt <= 1'b0;
      r_coreWfi <= 1'b0;
      r_wakeEvt <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_wakeCnt <= w_wakeCntNext;
      r_wfiAck  <= w_wfiAckNext;
      r_ifuHalt <= w_ifuHaltNext;
      r_coreWfi <= w_coreWfiNext;
      r_wakeEvt <= w_wakeEvtNext;
    end
  end

  assign wfi_ack      = r_wfiAck;
  assign ifu_halt_req = r_ifuHalt;
  assign core_wfi     = r_coreWfi;
  assign wake_evt     = r_wakeEvt;

  qpu_sleep_ctrl_act_hold #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_exuHold (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_busy   (exu_busy),
    .o_active (exu_active)
  );

  qpu_sleep_ctrl_act_hold #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_lsuHold (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_busy   (lsu_busy),
    .o_active (lsu_active)
  );

  qpu_sleep_ctrl_act_hold #(.HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) u_biuHold (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_busy   (biu_busy),
    .o_active (biu_active)
  );

endmodule

// File: tb/tb_qpu_sleep_ctrl.sv
// Testbench for qpu_sleep_ctrl: directed scenarios plus random traffic,
// compared through a scoreboard against a behavioural model.
module tb_qpu_sleep_ctrl;

  localparam int HOLD_CYC = 4;
  localparam int WAKE_CYC = 2;
  localparam int CNT_W    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wfi_req = 1'b0;
  logic ifu_halt_ack = 1'b0;
  logic exu_busy = 1'b0;
  logic lsu_busy = 1'b0;
  logic biu_busy = 1'b0;
  logic irq_pend = 1'b0;
  logic dbg_halt = 1'b0;
  logic wfi_ack, ifu_halt_req, core_wfi, wake_evt;
  logic exu_active, lsu_active, biu_active;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  qpu_sleep_ctrl #(.HOLD_CYC(HOLD_CYC), .WAKE_CYC(WAKE_CYC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wfi_req      (wfi_req),
    .wfi_ack      (wfi_ack),
    .ifu_halt_req (ifu_halt_req),
    .ifu_halt_ack (ifu_halt_ack),
    .exu_busy     (exu_busy),
    .lsu_busy     (lsu_busy),
    .biu_busy     (biu_busy),
    .irq_pend     (irq_pend),
    .dbg_halt     (dbg_halt),
    .core_wfi     (core_wfi),
    .exu_active   (exu_active),
    .lsu_active   (lsu_active),
    .biu_active   (biu_active),
    .wake_evt     (wake_evt)
  );

  typedef struct {
    int         cyc;
    logic       ack;
    logic       halt;
    logic       wfi;
    logic       evt;
    logic [2:0] act;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  bit   monEnable = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Behavioural model: what the sequencer is doing, in plain terms.
  bit mHalting;
  bit mAsleep;
  bit mWaking;
  int mWakeLeft;
  bit mAckNow;
  bit mEvtNow;
  int cyc;
  int lastBusy[3];

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mHalting  = 1'b0;
    mAsleep   = 1'b0;
    mWaking   = 1'b0;
    mWakeLeft = 0;
    mAckNow   = 1'b0;
    mEvtNow   = 1'b0;
    cyc       = 0;
    for (int u = 0; u < 3; u++) lastBusy[u] = -1;
  endtask

  // One clock of the sequencer's rules, consuming this cycle's inputs.
  task automatic modelStep(input logic req, input logic haltAck, input logic [2:0] busy,
                           input logic irq, input logic dbg);
    bit wake;
    bit drained;
    bit newAck;
    bit newEvt;
    int wakeLen;
    wake    = irq || dbg;
    drained = haltAck && (busy == 3'b000);
    newAck  = 1'b0;
    newEvt  = 1'b0;
    wakeLen = (WAKE_CYC > 0) ? WAKE_CYC : 1;
    if (mWaking) begin
      mWakeLeft--;
      if (mWakeLeft == 0) begin
        mWaking  = 1'b0;
        mHalting = 1'b0;
        newAck   = 1'b1;
      end
    end else if (mAsleep) begin
      if (wake) begin
        mAsleep   = 1'b0;
        mWaking   = 1'b1;
        mWakeLeft = wakeLen;
        newEvt    = 1'b1;
      end
    end else if (mHalting) begin
      if (wake) begin
        mWaking   = 1'b1;
        mWakeLeft = wakeLen;
      end else if (drained) begin
        mAsleep = 1'b1;
      end
    end else if (req && !mAckNow) begin
      if (wake) newAck = 1'b1;
      else mHalting = 1'b1;
    end
    mAckNow = newAck;
    mEvtNow = newEvt;
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance the model.
  task automatic applyStimulus(input logic req, input logic haltAck, input logic exuB,
                               input logic lsuB, input logic biuB, input logic irq,
                               input logic dbg);
    exp_t       e;
    logic [2:0] busy;
    wfi_req      = req;
    ifu_halt_ack = haltAck;
    exu_busy     = exuB;
    lsu_busy     = lsuB;
    biu_busy     = biuB;
    irq_pend     = irq;
    dbg_halt     = dbg;
    busy   = {biuB, lsuB, exuB};
    e.cyc  = cyc;
    e.ack  = mAckNow;
    e.halt = mHalting;
    e.wfi  = mAsleep;
    e.evt  = mEvtNow;
    for (int u = 0; u < 3; u++) e.act[u] = busy[u] || ((cyc - lastBusy[u]) <= HOLD_CYC);
    sbQ.push_back(e);
    modelStep(req, haltAck, busy, irq, dbg);
    for (int u = 0; u < 3; u++) if (busy[u]) lastBusy[u] = cyc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expectation per cycle at the falling edge.
  always @(negedge clk) begin
    if (monEnable) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        monE = sbQ.pop_front();
        checkOutput($sformatf("c%0d wfi_ack", monE.cyc), wfi_ack, monE.ack);
        checkOutput($sformatf("c%0d ifu_halt_req", monE.cyc), ifu_halt_req, monE.halt);
        checkOutput($sformatf("c%0d core_wfi", monE.cyc), core_wfi, monE.wfi);
        checkOutput($sformatf("c%0d wake_evt", monE.cyc), wake_evt, monE.evt);
        checkOutput($sformatf("c%0d exu_active", monE.cyc), exu_active, monE.act[0]);
        checkOutput($sformatf("c%0d lsu_active", monE.cyc), lsu_active, monE.act[1]);
        checkOutput($sformatf("c%0d biu_active", monE.cyc), biu_active, monE.act[2]);
      end
    end
  end

  // Release reset just after a rising edge and restart the model.
  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    sbQ.delete();
    monEnable = 1'b1;
  endtask

  // Random traffic that honours the EXU request/acknowledge handshake.
  task automatic randomPhase(input int n);
    bit reqLevel;
    bit dropPending;
    reqLevel    = 1'b0;
    dropPending = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (dropPending) begin
        reqLevel    = ($urandom_range(0, 3) == 0);
        dropPending = 1'b0;
      end else if (!reqLevel && $urandom_range(0, 5) == 0) begin
        reqLevel = 1'b1;
      end
      if (mAckNow) dropPending = 1'b1;
      applyStimulus(reqLevel, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 29) == 0));
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed scenarios, random traffic.
  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset core_wfi", core_wfi, 1'b0);
    checkOutput("reset ifu_halt_req", ifu_halt_req, 1'b0);
    checkOutput("reset wfi_ack", wfi_ack, 1'b0);
    releaseReset();

    // Idle after reset: active flags stretch then fall.
    repeat (7) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // WFI with interrupt pending is a NOP.
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Full sleep: IFU halt ack after 3, LSU drains after 5, then IRQ wake.
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    for (int i = 1; i < 4; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 1, 0);
    repeat (3) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Wake source in the same DRAIN cycle that drain completes.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 1, 0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // BIU pulse while asleep must not wake the core.
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    repeat (7) applyStimulus(1, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset while asleep.
    #2;
    monEnable = 1'b0;
    checkOutput("pre-reset core_wfi", core_wfi, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset core_wfi", core_wfi, 1'b0);
    checkOutput("async reset ifu_halt_req", ifu_halt_req, 1'b0);
    wfi_req      = 1'b0;
    ifu_halt_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("in-reset wfi_ack", wfi_ack, 1'b0);
      checkOutput("in-reset core_wfi", core_wfi, 1'b0);
    end
    releaseReset();
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    randomPhase(3000);

    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
